// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared FSM state type and sizing constants for gpio_out_arbiter.
package gpio_arb_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_t;
  localparam int MAX_REQ = 8;
  localparam int CNT_W = 4;
endpackage

// File: rtl/gpio_out_arbiter_if.sv
// gpio_out_arbiter_if: requester/arbiter bus for the shared GPIO_OUT bank.
// master (requesters): drives REQ, WR_DATA, WR_MASK; sees GNT, GPIO_OUT, BUSY, LAST_GNT_ID.
// slave (arbiter): the reverse.
interface gpio_out_arbiter_if #(parameter int NUM_REQ = 4, parameter int WIDTH = 32);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0]       REQ;
  logic [NUM_REQ*WIDTH-1:0] WR_DATA;
  logic [NUM_REQ*WIDTH-1:0] WR_MASK;
  logic [NUM_REQ-1:0]       GNT;
  logic [WIDTH-1:0]         GPIO_OUT;
  logic                     BUSY;
  logic [IDW-1:0]           LAST_GNT_ID;
  modport master(output REQ, WR_DATA, WR_MASK, input GNT, GPIO_OUT, BUSY, LAST_GNT_ID);
  modport slave(input REQ, WR_DATA, WR_MASK, output GNT, GPIO_OUT, BUSY, LAST_GNT_ID);
endinterface

// File: rtl/gpio_out_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// req_i request vector, last_i previous winner; search begins at last_i+1 with wrap.
// onehot_o / idx_o winner, valid_o any request present.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [N-1:0]   onehot_o,
  output logic [IDW-1:0] idx_o,
  output logic           valid_o
);
  int j;
  always_comb begin
    valid_o = 1'b0;
    idx_o = '0;
    j = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o = 1'b1;
        idx_o = IDW'(j);
      end
    end
    onehot_o = valid_o ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/gpio_out_arbiter.sv
// gpio_out_arbiter: round-robin masked read-modify-write arbiter for the GPIO_OUT bank.
// CLK/RESET: clock and async active-high reset; bus: slave side of gpio_out_arbiter_if.
module gpio_out_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int               NUM_REQ       = 4,
  parameter int               WIDTH         = 32,
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input logic CLK,
  input logic RESET,
  gpio_out_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] win;
  logic [IDW-1:0]     last_q;
  logic [IDW-1:0]     win_idx;
  logic [IDW-1:0]     search_last;
  logic               win_valid;
  logic               fresh_q;
  logic               busy_q;
  logic [WIDTH-1:0]   gpio_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   mask_q;
  logic [CNT_W-1:0]   cnt_q;
  // Until the first grant after reset, pretend the last winner was the top
  // requester so the search begins at requester 0.
  assign search_last = fresh_q ? IDW'(NUM_REQ - 1) : last_q;
  rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .req_i   (bus.REQ),
    .last_i  (search_last),
    .onehot_o(win),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= '0;
      fresh_q <= 1'b1;
      busy_q  <= 1'b0;
      gpio_q  <= RESET_VALUE;
      data_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (win_valid) begin
          data_q  <= bus.WR_DATA[int'(win_idx)*WIDTH +: WIDTH];
          mask_q  <= bus.WR_MASK[int'(win_idx)*WIDTH +: WIDTH];
          gnt_q   <= win;
          last_q  <= win_idx;
          fresh_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= APPLY;
        end
        APPLY: begin
          gpio_q  <= (gpio_q & ~mask_q) | (data_q & mask_q);
          gnt_q   <= '0;
          cnt_q   <= '0;
          busy_q  <= SETTLE_CYCLES > 0;
          state_q <= (SETTLE_CYCLES > 0) ? SETTLE : IDLE;
        end
        SETTLE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.GNT         = gnt_q;
  assign bus.GPIO_OUT    = gpio_q;
  assign bus.BUSY        = busy_q;
  assign bus.LAST_GNT_ID = last_q;
endmodule

// File: tb/tb_gpio_out_arbiter.sv
// tb_gpio_out_arbiter: vector table, corner sequences and random model checks for gpio_out_arbiter.
module tb_gpio_out_arbiter;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;
  logic [3:0]   req_v[2];
  logic [127:0] wd_v[2];
  logic [127:0] wm_v[2];
  logic [3:0]   gnt_v[2];
  logic [31:0]  gpio_v[2];
  logic         busy_v[2];
  logic [1:0]   last_v[2];
  gpio_out_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) ifa();
  gpio_out_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) ifb();
  assign ifa.REQ = req_v[0];
  assign ifa.WR_DATA = wd_v[0];
  assign ifa.WR_MASK = wm_v[0];
  assign ifb.REQ = req_v[1];
  assign ifb.WR_DATA = wd_v[1];
  assign ifb.WR_MASK = wm_v[1];
  assign gnt_v[0] = ifa.GNT;
  assign gpio_v[0] = ifa.GPIO_OUT;
  assign busy_v[0] = ifa.BUSY;
  assign last_v[0] = ifa.LAST_GNT_ID;
  assign gnt_v[1] = ifb.GNT;
  assign gpio_v[1] = ifb.GPIO_OUT;
  assign busy_v[1] = ifb.BUSY;
  assign last_v[1] = ifb.LAST_GNT_ID;
  gpio_out_arbiter #(.NUM_REQ(4), .WIDTH(32), .SETTLE_CYCLES(2), .RESET_VALUE(32'h0000_00FF)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(ifa));
  gpio_out_arbiter #(.NUM_REQ(4), .WIDTH(32), .SETTLE_CYCLES(0), .RESET_VALUE(32'h0)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(ifb));
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic pulse_rst;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask
  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (busy_v[k] && n < 20) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy_v[k]), 32'd0);
  endtask
  // Reference model: each accepted write blocks new sampling for 1+settle
  // edges; the write lands on the edge after acceptance.
  int          m_s[2] = '{2, 0};
  logic [31:0] m_rv[2] = '{32'h0000_00FF, 32'h0};
  int          m_gap[2], m_ptr[2], m_last[2];
  logic [31:0] m_img[2], m_pd[2], m_pm[2];
  bit          m_pend[2], m_busy[2];
  logic [3:0]  m_gnt[2];
  task automatic model_reset(input int k);
    m_gap[k] = 0;
    m_ptr[k] = 0;
    m_last[k] = 0;
    m_img[k] = m_rv[k];
    m_pend[k] = 0;
    m_busy[k] = 0;
    m_gnt[k] = '0;
  endtask
  task automatic model_step(input int k);
    int j;
    m_gnt[k] = '0;
    if (m_pend[k]) begin
      m_img[k] = (m_img[k] & ~m_pm[k]) | (m_pd[k] & m_pm[k]);
      m_pend[k] = 0;
    end
    if (m_gap[k] == 0) begin
      for (int o = 0; o < 4; o++) begin
        j = (m_ptr[k] + o) % 4;
        if (m_gnt[k] == 0 && req_v[k][j]) begin
          m_gnt[k][j] = 1'b1;
          m_last[k] = j;
          m_ptr[k] = (j + 1) % 4;
          m_pend[k] = 1;
          m_pd[k] = wd_v[k][j*32 +: 32];
          m_pm[k] = wm_v[k][j*32 +: 32];
          m_gap[k] = 1 + m_s[k];
        end
      end
    end else m_gap[k]--;
    m_busy[k] = m_gap[k] != 0;
  endtask
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [31:0] mask;
    logic [3:0]  gnt;
    logic [31:0] gpio;
    int          id;
  } vec_t;
  vec_t tbl[7];
  initial begin
    logic [3:0] gv[5];
    int gt[5];
    int ng;
    int low_cnt;
    int fair_id[5] = '{0, 1, 2, 3, 0};
    tbl[0] = '{4'b0010, 32'hA5A5_0000, 32'hFFFF_0000, 4'b0010, 32'hA5A5_00FF, 1};
    tbl[1] = '{4'b0001, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0001, 32'h0000_0000, 0};
    tbl[2] = '{4'b0001, 32'h0000_0001, 32'h0000_000F, 4'b0001, 32'h0000_0001, 0};
    tbl[3] = '{4'b0100, 32'h0000_000F, 32'h0000_0002, 4'b0100, 32'h0000_0003, 2};
    tbl[4] = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000, 32'h0000_0003, 3};
    tbl[5] = '{4'b1111, 32'hDEAD_0000, 32'hFFFF_0000, 4'b0001, 32'hDEAD_0003, 0};
    tbl[6] = '{4'b1010, 32'h0000_0000, 32'h0000_FFFF, 4'b0010, 32'hDEAD_0000, 1};
    for (int k = 0; k < 2; k++) begin
      req_v[k] = '0;
      wd_v[k] = '0;
      wm_v[k] = '0;
    end
    #3 RESET = 1'b1;
    #1;
    chk("rst_async_gpio", gpio_v[0], 32'h0000_00FF);
    chk("rst_async_gnt", 32'(gnt_v[0]), 32'd0);
    chk("rst_async_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_async_last", 32'(last_v[0]), 32'd0);
    tick();
    RESET = 1'b0;
    for (int e = 0; e < 7; e++) begin
      req_v[0] = tbl[e].req;
      wd_v[0] = {4{tbl[e].data}};
      wm_v[0] = {4{tbl[e].mask}};
      tick();
      chk($sformatf("vec%0d_gnt", e), 32'(gnt_v[0]), 32'(tbl[e].gnt));
      chk($sformatf("vec%0d_busy", e), 32'(busy_v[0]), 32'd1);
      req_v[0] = '0;
      tick();
      chk($sformatf("vec%0d_gpio", e), gpio_v[0], tbl[e].gpio);
      chk($sformatf("vec%0d_last", e), 32'(last_v[0]), 32'(tbl[e].id));
      chk($sformatf("vec%0d_gnt_drop", e), 32'(gnt_v[0]), 32'd0);
      wait_idle(0);
    end
    req_v[0] = 4'b0010;
    wd_v[0] = {4{32'h1234_5678}};
    wm_v[0] = {4{32'hFFFF_FFFF}};
    tick();
    chk("rapply_gnt", 32'(gnt_v[0]), 32'b0010);
    req_v[0] = '0;
    #2 RESET = 1'b1;
    #1;
    chk("rapply_gpio_async", gpio_v[0], 32'h0000_00FF);
    chk("rapply_gnt_async", 32'(gnt_v[0]), 32'd0);
    chk("rapply_busy_async", 32'(busy_v[0]), 32'd0);
    chk("rapply_last_async", 32'(last_v[0]), 32'd0);
    tick();
    RESET = 1'b0;
    tick();
    chk("rapply_not_applied", gpio_v[0], 32'h0000_00FF);
    req_v[0] = 4'b0110;
    wd_v[0] = '0;
    wm_v[0] = {4{32'h0000_00F0}};
    tick();
    chk("rapply_restart_gnt", 32'(gnt_v[0]), 32'b0010);
    req_v[0] = '0;
    tick();
    chk("rapply_restart_gpio", gpio_v[0], 32'h0000_000F);
    wait_idle(0);
    pulse_rst();
    req_v[0] = 4'b1111;
    wm_v[0] = '0;
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      tick();
      if (gnt_v[0] != 0) begin
        gv[ng] = gnt_v[0];
        gt[ng] = c;
        ng++;
      end
    end
    chk("fair_count", 32'(ng), 32'd5);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("fair_gnt%0d", i), 32'(gv[i]), 32'(1) << fair_id[i]);
      if (i > 0) chk($sformatf("fair_gap%0d", i), 32'(gt[i] - gt[i-1]), 32'd4);
    end
    req_v[0] = '0;
    wait_idle(0);
    pulse_rst();
    req_v[1] = 4'b1001;
    ng = 0;
    low_cnt = 0;
    gt[0] = 0;
    gt[1] = 0;
    for (int c = 0; c < 20 && ng < 2; c++) begin
      tick();
      if (gnt_v[1] != 0) begin
        gv[ng] = gnt_v[1];
        gt[ng] = c;
        ng++;
      end else if (ng == 1 && !busy_v[1]) low_cnt++;
    end
    chk("b2b_count", 32'(ng), 32'd2);
    if (ng == 2) begin
      chk("b2b_first", 32'(gv[0]), 32'b0001);
      chk("b2b_second", 32'(gv[1]), 32'b1000);
    end
    chk("b2b_gap", 32'(gt[1] - gt[0]), 32'd2);
    chk("b2b_busy_low", 32'(low_cnt), 32'd1);
    req_v[1] = '0;
    RESET = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK);
      for (int k = 0; k < 2; k++) if (RESET) model_reset(k); else model_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd%0d_gnt", k), 32'(gnt_v[k]), 32'(m_gnt[k]));
        chk($sformatf("rnd%0d_gpio", k), gpio_v[k], m_img[k]);
        chk($sformatf("rnd%0d_busy", k), 32'(busy_v[k]), 32'(m_busy[k]));
        chk($sformatf("rnd%0d_last", k), 32'(last_v[k]), 32'(m_last[k]));
        for (int i = 0; i < 4; i++) begin
          if ((m_gnt[k][i] && $urandom_range(0, 1) == 1) || (!req_v[k][i] && $urandom_range(0, 3) == 0)) begin
            req_v[k][i] = 1'b1;
            wd_v[k][i*32 +: 32] = $urandom;
            case ($urandom_range(0, 3))
              0: wm_v[k][i*32 +: 32] = 32'h0;
              1: wm_v[k][i*32 +: 32] = 32'hFFFF_FFFF;
              default: wm_v[k][i*32 +: 32] = $urandom;
            endcase
          end else if (m_gnt[k][i]) req_v[k][i] = 1'b0;
        end
      end
      if (RESET) RESET = 1'b0;
      else if ($urandom_range(0, 149) == 0) RESET = 1'b1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_out_arbiter.md
# gpio_out_arbiter

Round-robin write arbiter that lets several fabric requesters share the 32-bit `GPIO_OUT` bank of the MSS GPIO block. Each requester posts a masked read-modify-write; the arbiter grants one per slot, applies it to a registered output image, and enforces a programmable settle gap before the next write. It sits between fabric controllers and the `GPIO_OUT` pins, so no two writers ever race on the shared bank.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `WIDTH`, 32, GPIO bank width.
- `SETTLE_CYCLES`, 2, idle cycles after each applied write (0..15).
- `RESET_VALUE`, 32'h0, `GPIO_OUT` value while in reset.

Ports:
- `CLK` in 1: single clock.
- `RESET` in 1: asynchronous, active-high reset.
- `REQ` in NUM_REQ: per-requester write request, level.
- `WR_DATA` in NUM_REQ*WIDTH: requester i uses slice [i*WIDTH +: WIDTH].
- `WR_MASK` in NUM_REQ*WIDTH: 1 = bit is written, 0 = bit is kept; same slicing.
- `GNT` out NUM_REQ: one-hot, single-cycle grant/accept pulse.
- `GPIO_OUT` out WIDTH: registered output image, drives the GPIO bank.
- `BUSY` out 1: high when state ≠ IDLE.
- `LAST_GNT_ID` out clog2(NUM_REQ): index of the most recent grant.

## Operation
- FSM states:
  - IDLE: if `REQ` ≠ 0, select a winner, latch its data/mask, pulse `GNT[w]`, go to APPLY.
  - APPLY: `GPIO_OUT <= (GPIO_OUT & ~mask) | (data & mask)`, drop `GNT`. Go to SETTLE if `SETTLE_CYCLES` > 0, else IDLE.
  - SETTLE: 4-bit counter runs `SETTLE_CYCLES` cycles, then IDLE.
- Winner selection:
  - Round-robin, searching from `(LAST_GNT_ID+1) mod NUM_REQ` upward with wrap.
  - After reset the search starts at requester 0.
- `REQ` is sampled only in IDLE. Requests arriving during APPLY or SETTLE wait; nothing is dropped.
- Requester rules:
  - Hold `REQ`, `WR_DATA` and `WR_MASK` stable until `GNT` is seen.
  - `REQ` must be low by the edge ending the `GNT` cycle, unless another write is intended.
  - `REQ` still high when the arbiter next samples in IDLE counts as a new request.
- Zero mask: the request is still granted and consumes a slot; `GPIO_OUT` is unchanged.
- Overlapping masks from successive writers: the later write wins on shared bits. Masking is purely bitwise.
- Reset values: `GPIO_OUT=RESET_VALUE`, `GNT=0`, `BUSY=0`, `LAST_GNT_ID=0`, state IDLE, settle counter 0.
- Reset asserted mid-operation aborts the pending write (it is never applied), clears all state, and forces `GPIO_OUT` to `RESET_VALUE` immediately.

## Timing
- Latency:
  - `REQ` high at edge N (state IDLE) → `GNT` high in cycle N..N+1.
  - `GPIO_OUT` updated at edge N+1.
- Slot length is 2+`SETTLE_CYCLES` cycles, so with all requesters active each gets one write per NUM_REQ*(2+SETTLE_CYCLES) cycles.
- `BUSY` rises with `GNT` and falls on the edge that returns to IDLE.
- All outputs are registered; there is no combinational path from `REQ` to `GNT`.

## Structure
- Package `gpio_arb_pkg`:
  - state enum (IDLE, APPLY, SETTLE);
  - `MAX_REQ=8`;
  - settle counter width constant.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector and last index.
  - Outputs: one-hot winner, winner index, valid.
- Top level holds the FSM, the latched data/mask registers, the `GPIO_OUT` register and the settle counter.

## Test plan
- **Reset.** `RESET_VALUE=32'h0000_00FF`, pulse `RESET` mid-cycle → `GPIO_OUT=0x000000FF`, `GNT=0`, `BUSY=0` asynchronously.
- **Single write.** `REQ[1]`, data `0xA5A5_0000`, mask `0xFFFF_0000`, from `0x000000FF` → `GNT=4'b0010` one cycle later; `GPIO_OUT=0xA5A5_00FF` the cycle after; `LAST_GNT_ID=1`.
- **Round-robin fairness.** All four `REQ` held continuously (requesters re-request after `GNT`), `SETTLE_CYCLES=2` → grant order 0,1,2,3,0 with exactly 4 cycles between `GNT` pulses.
- **Overlap and zero mask.**
  - `REQ[0]` data `0x1` mask `0xF`, then `REQ[2]` data `0xF` mask `0x2`, from `0x0` → final `GPIO_OUT=0x3`.
  - A following zero-mask request is granted; `GPIO_OUT` stays `0x3`.
- **Back-to-back.** `SETTLE_CYCLES=0`, `REQ[3]` and `REQ[0]` held → grants 2 cycles apart, order 0 then 3; `BUSY` drops for exactly one cycle between them.
- **Reset mid-APPLY.** Assert `RESET` in the cycle after `GNT` → the write is not applied, `GPIO_OUT=RESET_VALUE`, and the next grant search starts at requester 0.
